// File: rtl/io_responder_pkg.sv
// Shared constants and helpers for the CPU I/O responder: default byte width,
// output FIFO depth and the saturating drop counter increment.
package io_responder_pkg;

  localparam int IO_WIDTH  = 8;
  localparam int IO_DEPTH  = 4;
  localparam int CNT_WIDTH = 8;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/io_responder_sync_fifo.sv
// Synchronous FIFO: registered write, combinational head read, no fall-through.
// Caller must gate push against full and pop against empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   async_nreset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/io_responder.sv
// CPU I/O device end: OUT bytes queue to a valid/ready consumer, IN reads a holding register.
// No CPU backpressure: writes to a full FIFO are dropped and counted; IN has 1-cycle latency.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int WIDTH = IO_WIDTH,
  parameter int DEPTH = IO_DEPTH
) (
  input  logic                   clk,
  input  logic                   async_nreset,
  input  logic [WIDTH-1:0]       cpu_io_data,
  input  logic                   cpu_io_write,
  output logic [WIDTH-1:0]       cpu_io_rdata,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  input  logic                   ovf_clear,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees a slot, so a write to a full FIFO still lands.
  assign push      = cpu_io_write && (!full || pop);
  assign drop      = cpu_io_write && full && !pop;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk          (clk),
    .async_nreset (async_nreset),
    .push         (push),
    .wr_data      (cpu_io_data),
    .pop          (pop),
    .rd_data      (out_data),
    .full         (full),
    .empty        (empty),
    .level        (level)
  );

  // A drop in the same cycle as a clear wins: the new count starts at one.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= ovf_clear ? CNT_WIDTH'(1) : sat_inc(drop_count);
    end else if (ovf_clear) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset)  cpu_io_rdata <= '0;
    else if (in_valid)  cpu_io_rdata <= in_data;
  end

endmodule

// File: tb/tb_io_responder.sv
// Randomized and directed checks of io_responder against a queue-based reference model.
module tb_io_responder;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         async_nreset = 1'b0;
  logic [W-1:0] cpu_io_data = '0;
  logic         cpu_io_write = 1'b0;
  logic [W-1:0] cpu_io_rdata;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         ovf_clear = 1'b0;
  logic [2:0]   level;
  logic         overflow;
  logic [7:0]   drop_count;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference state
  logic [W-1:0] m_q[$];
  logic         m_ovf;
  int           m_cnt;
  logic [W-1:0] m_rdata;

  io_responder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .cpu_io_data  (cpu_io_data),
    .cpu_io_write (cpu_io_write),
    .cpu_io_rdata (cpu_io_rdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .ovf_clear    (ovf_clear),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_ovf   = 1'b0;
    m_cnt   = 0;
    m_rdata = '0;
  endfunction

  function automatic void model_edge();
    bit pop  = (m_q.size() > 0) && out_ready;
    bit full = (m_q.size() == D);
    bit drop = cpu_io_write && full && !pop;
    bit push = cpu_io_write && (!full || pop);
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(cpu_io_data);
    if (drop) begin
      m_ovf = 1'b1;
      m_cnt = ovf_clear ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (ovf_clear) begin
      m_ovf = 1'b0;
      m_cnt = 0;
    end
    if (in_valid) m_rdata = in_data;
  endfunction

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("out_data", 32'(out_data), 32'(m_q[0]));
    check("level", 32'(level), 32'(m_q.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_cnt));
    check("cpu_io_rdata", 32'(cpu_io_rdata), 32'(m_rdata));
  endtask

  // Inputs are set before the call; model and DUT advance on the same edge.
  task automatic step();
    @(posedge clk);
    if (async_nreset) model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    cpu_io_write = 1'b0;
    out_ready    = 1'b0;
    in_valid     = 1'b0;
    ovf_clear    = 1'b0;
  endtask

  task automatic do_reset();
    cpu_io_data  = W'($urandom);
    cpu_io_write = 1'($urandom);
    out_ready    = 1'($urandom);
    in_data      = W'($urandom);
    in_valid     = 1'($urandom);
    ovf_clear    = 1'($urandom);
    async_nreset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_level", 32'(level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_drop_count", 32'(drop_count), 0);
    check("rst_rdata", 32'(cpu_io_rdata), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    idle();
    async_nreset = 1'b1;
    step();
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_level", 32'(level), 0);
  endtask

  task automatic write(input logic [W-1:0] b);
    cpu_io_write = 1'b1;
    cpu_io_data  = b;
    step();
    cpu_io_write = 1'b0;
  endtask

  task automatic drain_expect(input string tag, input logic [W-1:0] b);
    out_ready = 1'b1;
    check(tag, 32'(out_data), 32'(b));
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #3;
    do_reset();

    // Single byte
    write(8'hA5);
    check("a5_valid", 32'(out_valid), 1);
    check("a5_data", 32'(out_data), 32'h A5);
    check("a5_level", 32'(level), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("a5_pop_level", 32'(level), 0);
    check("a5_pop_valid", 32'(out_valid), 0);

    // Fill and one dropped write
    write(8'h11); write(8'h22); write(8'h33); write(8'h44); write(8'h55);
    check("fill_level", 32'(level), 4);
    check("fill_ovf", 32'(overflow), 1);
    check("fill_drops", 32'(drop_count), 1);
    drain_expect("drain0", 8'h11);
    drain_expect("drain1", 8'h22);
    drain_expect("drain2", 8'h33);
    drain_expect("drain3", 8'h44);
    check("drained_valid", 32'(out_valid), 0);

    // Full with simultaneous write and pop
    write(8'h11); write(8'h22); write(8'h33); write(8'h44);
    cpu_io_write = 1'b1; cpu_io_data = 8'h66; out_ready = 1'b1;
    step();
    idle();
    check("fullpp_level", 32'(level), 4);
    check("fullpp_ovf", 32'(overflow), 1);
    check("fullpp_drops", 32'(drop_count), 1);
    drain_expect("pp0", 8'h22);
    drain_expect("pp1", 8'h33);
    drain_expect("pp2", 8'h44);
    drain_expect("pp3", 8'h66);

    // Saturation
    for (int i = 0; i < D; i++) write(8'(i));
    cpu_io_write = 1'b1;
    for (int i = 0; i < 300; i++) begin
      cpu_io_data = W'($urandom);
      step();
    end
    cpu_io_write = 1'b0;
    check("sat_drops", 32'(drop_count), 255);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    check("clr_ovf", 32'(overflow), 0);
    check("clr_drops", 32'(drop_count), 0);
    write(8'h77);
    ovf_clear = 1'b1; cpu_io_write = 1'b1; cpu_io_data = 8'h88;
    step();
    idle();
    check("clr_drop_ovf", 32'(overflow), 1);
    check("clr_drop_cnt", 32'(drop_count), 1);

    // Input holding register
    in_valid = 1'b1; in_data = 8'h3C;
    step();
    in_valid = 1'b0; in_data = 8'hFF;
    check("in_3c", 32'(cpu_io_rdata), 32'h3C);
    step();
    check("in_hold", 32'(cpu_io_rdata), 32'h3C);
    in_valid = 1'b1; in_data = 8'h01;
    step();
    check("in_01", 32'(cpu_io_rdata), 32'h01);
    in_data = 8'h02;
    step();
    in_valid = 1'b0;
    check("in_02", 32'(cpu_io_rdata), 32'h02);

    // Mid-run reset empties the FIFO
    do_reset();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cpu_io_write = ($urandom_range(0, 99) < 60);
      cpu_io_data  = W'($urandom);
      out_ready    = ($urandom_range(0, 99) < 45);
      in_valid     = ($urandom_range(0, 99) < 30);
      in_data      = W'($urandom);
      ovf_clear    = ($urandom_range(0, 99) < 3);
      step();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
